// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FIFO depth default and
// sequencer state encoding.
package uart_pkg;

   localparam int unsigned DefaultDepth = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StWait  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with push, pop, synchronous flush and registered count.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte requesters feeding a shared FIFO, plus the
// start/busy handshake sequencer towards a uart_tx.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0_valid,
   input  logic [7:0]               req0_data,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic [7:0]               req1_data,
   output logic                     req1_ready,
   input  logic                     flush,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   input  logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     last_grant
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   tx_state_e  state_q, state_d;
   logic       tx_start_d;
   logic [7:0] tx_data_d;
   logic       full, grant_valid, grant, push, pop;
   logic [7:0] push_data, head;

   assign full = (fifo_count == CW'(DEPTH));

   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   end

   assign req0_ready = !full && !flush && grant_valid && !grant;
   assign req1_ready = !full && !flush && grant_valid && grant;
   assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign push_data  = grant ? req1_data : req0_data;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      tx_start_d = tx_start;
      tx_data_d  = tx_data;
      pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fifo_count != '0 && !flush) begin
               pop        = 1'b1;
               tx_data_d  = head;
               tx_start_d = 1'b1;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (tx_busy) begin
               tx_start_d = 1'b0;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (!tx_busy) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         last_grant <= 1'b1;
      end else begin
         state_q  <= state_d;
         tx_start <= tx_start_d;
         tx_data  <= tx_data_d;
         if (push) last_grant <= grant;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter against a queue-based model.
module tb_uart_tx_arbiter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0, tx_busy = 1'b0;
   logic [7:0]    req0_data = 8'h00, req1_data = 8'h00;
   logic          req0_ready, req1_ready, tx_start, last_grant;
   logic [7:0]    tx_data;
   logic [CW-1:0] fifo_count;

   int tests = 0;
   int fails = 0;

   byte unsigned m_q[$];
   byte unsigned exp_tx[$];
   int           m_phase = 0;
   bit           m_last = 1'b1;
   bit           m_acc0 = 1'b0, m_acc1 = 1'b0;
   bit           hold_busy = 1'b0, no_busy = 1'b0;
   int           busy_cnt = 0;

   uart_tx_arbiter #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .flush      (flush),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .last_grant (last_grant)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // -1 = no grant
   function automatic int model_grant();
      if (req0_valid && req1_valid) return m_last ? 0 : 1;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   // Reference model: FIFO as a queue, transmitter as idle/starting/waiting phase.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         m_acc0 = 1'b0;
         m_acc1 = 1'b0;
         if (!rst_n) begin
            m_q.delete();
            m_phase = 0;
            m_last  = 1'b1;
         end else begin : step_model
            int g;
            int pre;
            bit acc;
            g   = model_grant();
            pre = m_q.size();
            acc = (g >= 0) && (pre < DEPTH) && !flush;
            case (m_phase)
               0: if (pre > 0 && !flush) begin
                     exp_tx.push_back(m_q.pop_front());
                     m_phase = 1;
                  end
               1: if (tx_busy) m_phase = 2;
               default: if (!tx_busy) m_phase = 0;
            endcase
            if (flush) m_q.delete();
            else if (acc) begin
               m_q.push_back((g == 0) ? req0_data : req1_data);
               m_last = (g == 1);
               m_acc0 = (g == 0);
               m_acc1 = (g == 1);
            end
         end
      end
   end

   // Monitor: every new start strobe must carry the next expected byte.
   initial begin : monitor
      bit           prev;
      byte unsigned cur;
      prev = 1'b0;
      cur  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (tx_start && !prev) begin
            check("start_expected", int'(exp_tx.size() > 0), 1);
            if (exp_tx.size() > 0) begin
               cur = exp_tx.pop_front();
               check("tx_byte", tx_data, cur);
            end
         end else if (tx_start) begin
            check("tx_hold", tx_data, cur);
         end
         prev = tx_start;
      end
   end

   // Behavioural uart_tx busy responder, with occasional spurious busy.
   initial begin
      forever begin
         @(negedge clk);
         if (no_busy) tx_busy = 1'b0;
         else if (hold_busy) tx_busy = 1'b1;
         else if (busy_cnt > 0) begin
            busy_cnt--;
            tx_busy = (busy_cnt != 0);
         end else if (tx_start && $urandom_range(0, 1) == 1) begin
            tx_busy  = 1'b1;
            busy_cnt = $urandom_range(1, 4);
         end else begin
            tx_busy = ($urandom_range(0, 7) == 0);
         end
      end
   end

   task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                       input bit fl);
      int g;
      @(negedge clk);
      req0_valid = v0;
      req0_data  = d0;
      req1_valid = v1;
      req1_data  = d1;
      flush      = fl;
      #1;
      g = model_grant();
      check("req0_ready", req0_ready, int'(g == 0 && m_q.size() < DEPTH && !flush && rst_n));
      check("req1_ready", req1_ready, int'(g == 1 && m_q.size() < DEPTH && !flush && rst_n));
      check("fifo_count", fifo_count, m_q.size());
      check("last_grant", last_grant, m_last);
      check("tx_start", tx_start, int'(m_phase == 1));
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((m_q.size() != 0 || m_phase != 0) && n < max_cycles) begin
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
         n++;
      end
      check("drain_done", int'(m_q.size() == 0 && m_phase == 0), 1);
   endtask

   initial begin : timeout
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int n0, n1, n;
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_count", fifo_count, 0);
      check("rst_start", tx_start, 0);
      check("rst_data", tx_data, 0);
      check("rst_last_grant", last_grant, 1);
      rst_n = 1'b1;

      // Single byte
      step(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
      drain(40);

      // Contention, requesters each count up on acceptance
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'(8'h10 + n0), 1'b1, 8'(8'h20 + n1), 1'b0);
         @(posedge clk);
         #2;
         n0 += int'(m_acc0);
         n1 += int'(m_acc1);
      end
      drain(100);

      // Full with busy stuck in WAIT
      hold_busy = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h50 + i), 1'b0);
      check("full_count", fifo_count, DEPTH);
      hold_busy = 1'b0;
      drain(200);

      // Flush with three queued and one in WAIT; req1 byte in the flush cycle is dropped
      hold_busy = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("flush_count", fifo_count, 0);
      hold_busy = 1'b0;
      drain(50);

      // Wrap: ten sequential bytes
      n0 = 0;
      n  = 0;
      while (n0 < 10 && n < 300) begin
         step(1'b1, 8'(n0), 1'b0, 8'h00, 1'b0);
         @(posedge clk);
         #2;
         n0 += int'(m_acc0);
         n++;
      end
      check("wrap_sent", n0, 10);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      drain(300);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 31) == 0));
      end
      drain(300);

      // Asynchronous reset during START
      no_busy = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b0);
      n = 0;
      while (!tx_start && n < 20) begin
         step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
         n++;
      end
      check("start_seen", tx_start, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_start", tx_start, 0);
      check("async_rst_count", fifo_count, 0);
      check("async_rst_data", tx_data, 0);
      check("async_rst_grant", last_grant, 1);
      @(negedge clk);
      rst_n   = 1'b1;
      no_busy = 1'b0;
      drain(50);

      repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("scoreboard_empty", exp_tx.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
